// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined N-bit adder/subtractor.
package adder_pkg;

  localparam int unsigned DEFAULT_N      = 8;
  localparam int unsigned DEFAULT_STAGES = 2;

  // Width of one ripple slice: each pipeline stage handles N/STAGES bits.
  function automatic int unsigned slice_width(input int unsigned n, input int unsigned stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result handshake bundle for pipelined_adder_nbit.
interface pipelined_adder_nbit_if
  import adder_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  // Producer/consumer side (test system).
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry chain of full adders.
module adder_slice #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder/subtractor: STAGES registered ripple slices with a
// valid/ready handshake and a single global stall.
// Optional feature: define ADDER_OVF_EN to generate the signed-overflow flag;
// otherwise ovf is tied to 0.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned N      = DEFAULT_N,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_adder_nbit_if.slave bus
);

  localparam int unsigned W = slice_width(N, STAGES);

  if ((N % STAGES) != 0) begin : g_cfg_check
    $error("pipelined_adder_nbit: N must be a multiple of STAGES");
  end

  logic         advance;
  logic [N-1:0] b_eff;
  logic         carry0;

  // Whole pipe moves together unless the output is held by the consumer.
  assign advance      = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = advance;

  // Subtract as A + ~B + 1; cin has no effect in subtract mode.
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign carry0 = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when entering this stage (LSB-aligned).
    localparam int unsigned REM = N - k * W;

    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in;
    logic                   v_in;
    logic [W-1:0]           s_slice;
    logic                   c_out;
    logic [(k+1)*W-1:0]     sum_d;
    logic [(k+1)*W-1:0]     sum_q;
    logic                   c_q;
    logic                   v_q;

    if (k == 0) begin : g_src
      assign a_in  = bus.a;
      assign b_in  = b_eff;
      assign c_in  = carry0;
      assign v_in  = bus.in_valid;
      assign sum_d = s_slice;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_skew.a_q;
      assign b_in  = g_stage[k-1].g_skew.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {s_slice, g_stage[k-1].sum_q};
    end

    adder_slice #(.W(W)) u_slice (
      .a    (a_in[W-1:0]),
      .b    (b_in[W-1:0]),
      .cin  (c_in),
      .s    (s_slice),
      .cout (c_out)
    );

    // Stage register: valid bit always shifts on advance, payload only for real beats.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= c_out;
          sum_q <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-W-1:0] a_q;
      logic [REM-W-1:0] b_q;

      // Skew registers carry the unprocessed upper operand bits forward.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_in) begin
          a_q <= a_in[REM-1:W];
          b_q <= b_in[REM-1:W];
        end
      end
    end

`ifdef ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Signed overflow: like-signed operands producing a result of the other sign.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= (a_in[W-1] == b_in[W-1]) && (s_slice[W-1] != a_in[W-1]);
        end
      end
    end
`endif
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;

`ifdef ADDER_OVF_EN
  assign bus.ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Directed bench for pipelined_adder_nbit (N=8/STAGES=2 and N=16/STAGES=4).
module tb_pipelined_adder_nbit;

`ifdef ADDER_OVF_EN
  localparam int OVF_ON = 1;
`else
  localparam int OVF_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests  = 0;
  int   n_failed = 0;
  int   cyc;

  always #5 clk = ~clk;

  pipelined_adder_nbit_if #(.N(8))  bus8 ();
  pipelined_adder_nbit_if #(.N(16)) bus16 ();

  pipelined_adder_nbit #(.N(8), .STAGES(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  pipelined_adder_nbit #(.N(16), .STAGES(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the 8-bit adder for a single accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.sub      = sub;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result on the 8-bit adder and compare it.
  task automatic expect8(input string tag, input int s, input int co, input int ov);
    int n;
    n = 0;
    while (!bus8.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, " valid"}, 32'(bus8.out_valid), 1);
    check({tag, " sum"},   32'(bus8.sum),       s);
    check({tag, " cout"},  32'(bus8.cout),      co);
    check({tag, " ovf"},   32'(bus8.ovf),       ov);
  endtask

  initial begin
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0;
    bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst out_valid", 32'(bus8.out_valid), 0);
    check("rst sum",       32'(bus8.sum),       0);
    check("rst cout",      32'(bus8.cout),      0);
    check("rst ovf",       32'(bus8.ovf),       0);
    check("rst in_ready",  32'(bus8.in_ready),  1);
    check("rst16 valid",   32'(bus16.out_valid), 0);

    // 200+100: wraps, result after STAGES accepting edges
    send8(8'd200, 8'd100, 1'b0, 1'b0);
    check("lat early valid", 32'(bus8.out_valid), 0);
    tick();
    check("add200 valid", 32'(bus8.out_valid), 1);
    check("add200 sum",   32'(bus8.sum),       44);
    check("add200 cout",  32'(bus8.cout),      1);
    check("add200 ovf",   32'(bus8.ovf),       0);

    send8(8'd100, 8'd50, 1'b0, 1'b0);
    expect8("add100_50", 150, 0, OVF_ON);
    send8(8'h0F, 8'h01, 1'b0, 1'b0);
    expect8("slice_carry", 8'h10, 0, 0);
    send8(8'd5, 8'd7, 1'b1, 1'b1);
    expect8("sub5_7", 8'hFE, 0, 0);
    send8(8'h80, 8'h01, 1'b0, 1'b1);
    expect8("sub80_1", 8'h7F, 1, OVF_ON);
    send8(8'd10, 8'd20, 1'b1, 1'b0);
    expect8("add_cin", 31, 0, 0);

    // Back-to-back beats: one result per cycle, in order
    for (int i = 0; i < 4; i++) begin
      bus8.a = 8'(i + 1); bus8.b = 8'(i + 1); bus8.cin = 1'b0; bus8.sub = 1'b0;
      bus8.in_valid = 1'b1;
      tick();
      if (i >= 1) begin
        check("b2b valid", 32'(bus8.out_valid), 1);
        check("b2b sum",   32'(bus8.sum),       2 * i);
      end
    end
    bus8.in_valid = 1'b0;
    tick();
    check("b2b last valid", 32'(bus8.out_valid), 1);
    check("b2b last sum",   32'(bus8.sum),       8);
    tick();
    check("b2b drained", 32'(bus8.out_valid), 0);

    // Backpressure: fill, stall 3 cycles, release and drain
    bus8.out_ready = 1'b0;
    bus8.a = 8'd10; bus8.b = 8'd1; bus8.in_valid = 1'b1;
    tick();
    bus8.a = 8'd20; bus8.b = 8'd2;
    tick();
    bus8.a = 8'd30; bus8.b = 8'd3;
    for (int i = 0; i < 3; i++) begin
      check("stall in_ready", 32'(bus8.in_ready),  0);
      check("stall valid",    32'(bus8.out_valid), 1);
      check("stall sum",      32'(bus8.sum),       11);
      tick();
    end
    check("stall hold sum", 32'(bus8.sum), 11);
    bus8.out_ready = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check("drain1 valid", 32'(bus8.out_valid), 1);
    check("drain1 sum",   32'(bus8.sum),       22);
    tick();
    check("drain2 valid", 32'(bus8.out_valid), 1);
    check("drain2 sum",   32'(bus8.sum),       33);
    tick();
    check("drain empty", 32'(bus8.out_valid), 0);

    // N=16, STAGES=4: carry through every slice, 4-cycle latency
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    cyc = 0;
    while (!bus16.out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("w16 latency", 32'(cyc), 3);
    check("w16 valid",   32'(bus16.out_valid), 1);
    check("w16 sum",     32'(bus16.sum),       0);
    check("w16 cout",    32'(bus16.cout),      1);
    bus16.a = 16'h1234; bus16.b = 16'h0234; bus16.sub = 1'b1;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    cyc = 0;
    while (!bus16.out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("w16 sub valid", 32'(bus16.out_valid), 1);
    check("w16 sub sum",   32'(bus16.sum),       16'h1000);
    check("w16 sub cout",  32'(bus16.cout),      1);

    // Reset with two beats in flight discards them
    tick();
    send8(8'd1, 8'd1, 1'b0, 1'b0);
    send8(8'd2, 8'd2, 1'b0, 1'b0);
    check("pre-rst valid", 32'(bus8.out_valid), 1);
    rst = 1'b1;
    tick();
    check("rst flight valid", 32'(bus8.out_valid), 0);
    check("rst flight sum",   32'(bus8.sum),       0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post-rst idle", 32'(bus8.out_valid), 0);
      tick();
    end
    send8(8'd9, 8'd6, 1'b0, 1'b0);
    expect8("post-rst beat", 15, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_nbit.md
# pipelined_adder_nbit

Parametrised, pipelined N-bit adder/subtractor built from ripple-carry slices, with a valid/ready handshake on both sides. It is the next generation of the team's combinational N-bit ripple-carry adder. The carry chain is split into STAGES registered segments so wide adds close timing, and it adds carry-in, a subtract mode, backpressure and an optional signed-overflow flag. It sits between an operand producer and a result consumer in datapath test systems.

## Interface
- N, 8, operand/result width; N % STAGES must be 0
- STAGES, 2, pipeline depth; slice width W = N/STAGES; STAGES=1 gives a single registered ripple adder
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  N  operand A (unsigned/two's complement)
- b  in  N  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- sum  out  N  result
- cout  out  1  carry-out (sub=1: 1 = no borrow, i.e. A>=B unsigned)
- ovf  out  1  signed overflow (see Configuration)

## Operation
- Beat accepted when in_valid && in_ready.
- Effective operands: B' = sub ? ~b : b; carry0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) ripple-adds bits [k*W +: W] of A and B' with the carry registered from stage k-1. Stage 0 uses carry0. Unprocessed upper slices of A/B' and already-computed lower sum slices travel alongside in skew registers.
- Each stage holds a valid bit; bubbles propagate as invalid entries and are not collapsed.
- Global advance = !(out_valid && !out_ready). All stages shift only on advance. in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
- Final stage outputs sum, cout = carry out of bit N-1, ovf.
- Results emerge in acceptance order; none is dropped or duplicated.
- Arithmetic is modulo 2^N. cout captures bit N.

## Timing
- Reset: all stage valid bits 0. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 the cycle after rst deasserts.
- Latency: beat accepted at edge t produces out_valid=1 with its result after edge t+STAGES-1. It is visible in the cycle following the STAGES-th accepting edge, i.e. STAGES cycles accept-to-output.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall: out_valid && !out_ready freezes every stage. sum/cout/ovf/out_valid stay stable. in_ready=0.
- Simultaneous output pop and input push in one cycle are both honoured.
- rst mid-operation discards all in-flight beats. out_valid=0 from the next cycle. No stale result ever appears.

## Configuration
- ADDER_OVF_EN defined: ovf = (A[N-1] == B'[N-1]) && (sum[N-1] != A[N-1]), registered with sum.
- Not defined: ovf tied to 0 and the sign-tracking logic is not instantiated. The port remains so instantiations do not change.

## Structure
- Package adder_pkg: default width/depth constants and a function computing W = N/STAGES. Elaboration check that N % STAGES == 0.
- One sub-module: adder_slice, a combinational W-bit ripple carry of full adders (a, b, cin -> s, cout). It is instantiated STAGES times, with pipeline registers in the top.

## Test plan (N=8, STAGES=2 unless noted)
- a=200, b=100, cin=0, sub=0 -> sum=44, cout=1, ovf=0, out_valid 2 cycles after accept.
- a=100, b=50, sub=0 -> sum=150, cout=0, ovf=1 (ovf=0 without ADDER_OVF_EN). Also a=8'h0F, b=8'h01 -> sum=8'h10, carry crosses the slice boundary.
- a=5, b=7, sub=1, cin=1 -> sum=8'hFE, cout=0, ovf=0 (cin ignored).
- 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready=1 -> results 2, 4, 6, 8 on 4 consecutive cycles, in order.
- Fill pipe, hold out_ready=0 for 3 cycles -> in_ready=0, outputs stable. Release -> remaining results drain without loss or duplication.
- Assert rst with 2 beats in flight -> out_valid=0 next cycle and stays 0 until new beats are accepted. Repeat with N=16, STAGES=4: a=16'hFFFF, b=1 -> sum=0, cout=1.
